// File: rtl/mmio_pkg.sv
// rtl/mmio_pkg.sv - shared types, address field layout and helpers for the MMIO slot controller
package mmio_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_DONE
   } state_t;

   localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

   localparam int ADDR_W   = 21;
   localparam int SLOT_LSB = 5;
   localparam int SLOT_MSB = 10;
   localparam int SLOT_FW  = SLOT_MSB - SLOT_LSB + 1;
   localparam int REG_LSB  = 0;

   function automatic int slot_aw(input int n_slots);
      return $clog2(n_slots);
   endfunction

endpackage

// File: rtl/mmio_ctrl_hs_if.sv
// rtl/mmio_ctrl_hs_if.sv - FPRO bus side of the MMIO slot controller
interface mmio_ctrl_hs_if import mmio_pkg::*; #(
   parameter int DW = 32
) ();

   logic              mmio_cs;
   logic              mmio_wr;
   logic              mmio_rd;
   logic [ADDR_W-1:0] mmio_addr;
   logic [DW-1:0]     mmio_wr_data;
   logic [DW-1:0]     mmio_rd_data;
   logic              mmio_ready;
   logic              mmio_err;
   logic [ADDR_W-1:0] mmio_err_addr;
   logic              err_clr;

   modport master (
      output mmio_cs, mmio_wr, mmio_rd, mmio_addr, mmio_wr_data, err_clr,
      input  mmio_rd_data, mmio_ready, mmio_err, mmio_err_addr
   );

   modport slave (
      input  mmio_cs, mmio_wr, mmio_rd, mmio_addr, mmio_wr_data, err_clr,
      output mmio_rd_data, mmio_ready, mmio_err, mmio_err_addr
   );

endinterface

// File: rtl/mmio_timeout_cnt.sv
// rtl/mmio_timeout_cnt.sv - access timeout counter with clear, enable and expired flag
module mmio_timeout_cnt #(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   logic [CW-1:0] count;

   assign expired = (count == CW'(TIMEOUT - 1));

   // Saturates at the expiry value so a stalled enable cannot wrap.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && !expired) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/mmio_ctrl_hs.sv
// rtl/mmio_ctrl_hs.sv - handshaked MMIO slot controller with one-hot select, timeout and sticky error
module mmio_ctrl_hs import mmio_pkg::*; #(
   parameter int             N_SLOTS  = 64,
   parameter int             REG_AW   = 5,
   parameter int             DW       = 32,
   parameter int             TIMEOUT  = 255,
   parameter logic [DW-1:0]  ERR_DATA = DW'(ERR_DATA_DEF)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   mmio_ctrl_hs_if.slave         bus,
   input  logic [DW*N_SLOTS-1:0] slot_rd_data_array,
   input  logic [N_SLOTS-1:0]    slot_ack,
   output logic [N_SLOTS-1:0]    slot_cs_array,
   output logic                  slot_mem_rd,
   output logic                  slot_mem_wr,
   output logic [DW-1:0]         slot_wr_data,
   output logic [REG_AW-1:0]     slot_reg_addr
);

   localparam int SLOT_AW = slot_aw(N_SLOTS);

   state_t              state;
   state_t              next_state;
   logic [ADDR_W-1:0]   addr_q;
   logic [DW-1:0]       wdata_q;
   logic                op_rd;
   logic                op_wr;
   logic [DW-1:0]       rd_data_q;
   logic                err_q;
   logic [ADDR_W-1:0]   err_addr_q;

   logic [SLOT_FW-1:0]  slot_f;
   logic [SLOT_AW-1:0]  sel;
   logic [DW-1:0]       sel_data;
   logic                req;
   logic                in_access;
   logic                bad_req;
   logic                strobe_en;
   logic                hit;
   logic                expired;
   logic                err_set;

   assign slot_f    = addr_q[SLOT_MSB:SLOT_LSB];
   assign sel       = slot_f[SLOT_AW-1:0];
   assign sel_data  = slot_rd_data_array[int'(sel)*DW +: DW];
   assign req       = bus.mmio_cs && (bus.mmio_rd || bus.mmio_wr);
   assign in_access = (state == ST_ACCESS);
   assign bad_req   = ({1'b0, slot_f} >= (SLOT_FW + 1)'(N_SLOTS)) || (op_rd && op_wr);
   assign strobe_en = in_access && !bad_req;
   // Only the addressed slot's ack counts; ack beats a same-cycle timeout.
   assign hit       = strobe_en && slot_ack[sel];
   assign err_set   = in_access && (bad_req || (!hit && expired));

   mmio_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (!in_access),
      .enable  (in_access && !hit),
      .expired (expired)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state    = state;
      slot_cs_array = '0;
      slot_mem_rd   = 1'b0;
      slot_mem_wr   = 1'b0;
      bus.mmio_ready = 1'b0;
      case (state)
         ST_IDLE: begin
            if (req) next_state = ST_ACCESS;
         end
         ST_ACCESS: begin
            if (strobe_en) begin
               slot_cs_array = N_SLOTS'(1) << sel;
               slot_mem_rd   = op_rd;
               slot_mem_wr   = op_wr;
            end
            if (bad_req || hit || expired) next_state = ST_DONE;
         end
         ST_DONE: begin
            bus.mmio_ready = 1'b1;
            next_state     = ST_IDLE;
         end
         default: next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         addr_q     <= '0;
         wdata_q    <= '0;
         op_rd      <= 1'b0;
         op_wr      <= 1'b0;
         rd_data_q  <= '0;
         err_q      <= 1'b0;
         err_addr_q <= '0;
      end else begin
         if (state == ST_IDLE && req) begin
            addr_q  <= bus.mmio_addr;
            wdata_q <= bus.mmio_wr_data;
            op_rd   <= bus.mmio_rd;
            op_wr   <= bus.mmio_wr;
         end
         if (hit && op_rd) begin
            rd_data_q <= sel_data;
         end else if (err_set && op_rd) begin
            rd_data_q <= ERR_DATA;
         end
         if (err_set) begin
            err_q      <= 1'b1;
            err_addr_q <= addr_q;
         end else if (bus.err_clr) begin
            err_q <= 1'b0;
         end
      end
   end

   assign bus.mmio_rd_data  = rd_data_q;
   assign bus.mmio_err      = err_q;
   assign bus.mmio_err_addr = err_addr_q;
   assign slot_wr_data      = wdata_q;
   assign slot_reg_addr     = addr_q[REG_LSB +: REG_AW];

endmodule

// File: tb/tb_mmio_ctrl_hs.sv
// tb/tb_mmio_ctrl_hs.sv - directed self-checking bench for mmio_ctrl_hs (16 slots, timeout 8)
module tb_mmio_ctrl_hs;

   localparam int NS = 16;
   localparam int DW = 32;
   localparam int TO = 8;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic [DW*NS-1:0]  slot_data;
   logic [NS-1:0]     slot_ack;
   logic [NS-1:0]     slot_cs;
   logic              mem_rd;
   logic              mem_wr;
   logic [DW-1:0]     wr_data_o;
   logic [4:0]        reg_addr_o;

   int total = 0;
   int bad   = 0;

   mmio_ctrl_hs_if #(.DW(DW)) bus ();

   mmio_ctrl_hs #(.N_SLOTS(NS), .REG_AW(5), .DW(DW), .TIMEOUT(TO)) dut (
      .clk                (clk),
      .reset_n            (reset_n),
      .bus                (bus),
      .slot_rd_data_array (slot_data),
      .slot_ack           (slot_ack),
      .slot_cs_array      (slot_cs),
      .slot_mem_rd        (mem_rd),
      .slot_mem_wr        (mem_wr),
      .slot_wr_data       (wr_data_o),
      .slot_reg_addr      (reg_addr_o)
   );

   always #5 clk = ~clk;

   // Issues one request, then watches 14 cycles; ack_cyc==0 means the target never acks.
   task automatic run_txn(input logic [20:0] a, input logic r, input logic w, input logic [31:0] d,
                          input int ack_cyc, input int ack_slot, input logic [NS-1:0] noise,
                          output int rd_n, output int wr_n, output int cs_n, output int rdy_n,
                          output int ready_cyc, output logic [NS-1:0] cs_seen);
      rd_n = 0; wr_n = 0; cs_n = 0; rdy_n = 0; ready_cyc = 0; cs_seen = '0;
      bus.mmio_cs = 1'b1; bus.mmio_rd = r; bus.mmio_wr = w;
      bus.mmio_addr = a; bus.mmio_wr_data = d;
      @(posedge clk); #1;
      bus.mmio_cs = 1'b0; bus.mmio_rd = 1'b0; bus.mmio_wr = 1'b0;
      for (int cyc = 1; cyc <= 14; cyc++) begin
         if (mem_rd) rd_n++;
         if (mem_wr) wr_n++;
         if (|slot_cs) begin cs_n++; cs_seen = cs_seen | slot_cs; end
         if (bus.mmio_ready) begin
            rdy_n++;
            if (ready_cyc == 0) ready_cyc = cyc;
         end
         slot_ack = (cyc == ack_cyc) ? (NS'(1) << ack_slot) : noise;
         @(posedge clk); #1;
      end
      slot_ack = '0;
   endtask

   task automatic test_reset;
      total++; if (bus.mmio_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", bus.mmio_ready); end
      total++; if (bus.mmio_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", bus.mmio_err); end
      total++; if (bus.mmio_rd_data !== 32'h0) begin bad++; $display("FAIL reset_rd_data got=%h want=0", bus.mmio_rd_data); end
      total++; if (bus.mmio_err_addr !== 21'h0) begin bad++; $display("FAIL reset_err_addr got=%h want=0", bus.mmio_err_addr); end
      total++; if ({slot_cs, mem_rd, mem_wr} !== '0) begin bad++; $display("FAIL reset_strobes got=%h/%b/%b want=0", slot_cs, mem_rd, mem_wr); end
      total++; if ({wr_data_o, reg_addr_o} !== '0) begin bad++; $display("FAIL reset_bcast got=%h/%h want=0", wr_data_o, reg_addr_o); end
   endtask

   task automatic test_read_fast;
      int rd_n, wr_n, cs_n, rdy_n, rc; logic [NS-1:0] cs_seen;
      run_txn(21'h062, 1'b1, 1'b0, 32'h0, 1, 3, '0, rd_n, wr_n, cs_n, rdy_n, rc, cs_seen);
      total++; if (rc !== 2) begin bad++; $display("FAIL fast_ready_cycle got=%0d want=2", rc); end
      total++; if (rdy_n !== 1) begin bad++; $display("FAIL fast_ready_pulses got=%0d want=1", rdy_n); end
      total++; if (bus.mmio_rd_data !== 32'h1234_5678) begin bad++; $display("FAIL fast_rd_data got=%h want=12345678", bus.mmio_rd_data); end
      total++; if (cs_seen !== 16'h0008 || cs_n !== 1) begin bad++; $display("FAIL fast_cs got=%h x%0d want=0008 x1", cs_seen, cs_n); end
      total++; if (rd_n !== 1 || wr_n !== 0) begin bad++; $display("FAIL fast_strobes got rd=%0d wr=%0d want rd=1 wr=0", rd_n, wr_n); end
      total++; if (reg_addr_o !== 5'd2) begin bad++; $display("FAIL fast_reg_addr got=%0d want=2", reg_addr_o); end
   endtask

   task automatic test_write_slow;
      int rd_n, wr_n, cs_n, rdy_n, rc; logic [NS-1:0] cs_seen;
      run_txn(21'h147, 1'b0, 1'b1, 32'hA5A5_A5A5, 4, 10, '0, rd_n, wr_n, cs_n, rdy_n, rc, cs_seen);
      total++; if (wr_n !== 4 || rd_n !== 0) begin bad++; $display("FAIL write_strobes got wr=%0d rd=%0d want wr=4 rd=0", wr_n, rd_n); end
      total++; if (rc !== 5) begin bad++; $display("FAIL write_ready_cycle got=%0d want=5", rc); end
      total++; if (cs_seen !== 16'h0400) begin bad++; $display("FAIL write_cs got=%h want=0400", cs_seen); end
      total++; if (bus.mmio_err !== 1'b0) begin bad++; $display("FAIL write_err got=%b want=0", bus.mmio_err); end
      total++; if (bus.mmio_rd_data !== 32'h1234_5678) begin bad++; $display("FAIL write_rd_data_kept got=%h want=12345678", bus.mmio_rd_data); end
      total++; if (wr_data_o !== 32'hA5A5_A5A5 || reg_addr_o !== 5'd7) begin bad++; $display("FAIL write_bcast got=%h/%0d want=a5a5a5a5/7", wr_data_o, reg_addr_o); end
   endtask

   task automatic test_timeout;
      int rd_n, wr_n, cs_n, rdy_n, rc; logic [NS-1:0] cs_seen;
      run_txn(21'h0A1, 1'b1, 1'b0, 32'h0, 0, 0, '0, rd_n, wr_n, cs_n, rdy_n, rc, cs_seen);
      total++; if (rc !== 9) begin bad++; $display("FAIL timeout_ready_cycle got=%0d want=9", rc); end
      total++; if (rd_n !== 8) begin bad++; $display("FAIL timeout_rd_strobes got=%0d want=8", rd_n); end
      total++; if (bus.mmio_rd_data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL timeout_rd_data got=%h want=deadbeef", bus.mmio_rd_data); end
      total++; if (bus.mmio_err !== 1'b1) begin bad++; $display("FAIL timeout_err got=%b want=1", bus.mmio_err); end
      total++; if (bus.mmio_err_addr !== 21'h0A1) begin bad++; $display("FAIL timeout_err_addr got=%h want=0a1", bus.mmio_err_addr); end
      bus.err_clr = 1'b1; @(posedge clk); #1; bus.err_clr = 1'b0;
      total++; if (bus.mmio_err !== 1'b0) begin bad++; $display("FAIL err_clr got=%b want=0", bus.mmio_err); end
      total++; if (bus.mmio_err_addr !== 21'h0A1) begin bad++; $display("FAIL err_clr_addr_kept got=%h want=0a1", bus.mmio_err_addr); end
   endtask

   task automatic test_ack_at_timeout;
      int rd_n, wr_n, cs_n, rdy_n, rc; logic [NS-1:0] cs_seen;
      run_txn(21'h0E0, 1'b1, 1'b0, 32'h0, 8, 7, '0, rd_n, wr_n, cs_n, rdy_n, rc, cs_seen);
      total++; if (rc !== 9) begin bad++; $display("FAIL ack_to_ready_cycle got=%0d want=9", rc); end
      total++; if (bus.mmio_rd_data !== 32'h7777_0007) begin bad++; $display("FAIL ack_to_rd_data got=%h want=77770007", bus.mmio_rd_data); end
      total++; if (bus.mmio_err !== 1'b0) begin bad++; $display("FAIL ack_to_err got=%b want=0", bus.mmio_err); end
   endtask

   task automatic test_foreign_ack;
      int rd_n, wr_n, cs_n, rdy_n, rc; logic [NS-1:0] cs_seen;
      run_txn(21'h040, 1'b1, 1'b0, 32'h0, 3, 2, 16'hFFFB, rd_n, wr_n, cs_n, rdy_n, rc, cs_seen);
      total++; if (rc !== 4 || rd_n !== 3) begin bad++; $display("FAIL foreign_ack got ready=%0d rd=%0d want ready=4 rd=3", rc, rd_n); end
      total++; if (bus.mmio_rd_data !== 32'hC0DE_0002) begin bad++; $display("FAIL foreign_ack_data got=%h want=c0de0002", bus.mmio_rd_data); end
      total++; if (bus.mmio_err !== 1'b0) begin bad++; $display("FAIL foreign_ack_err got=%b want=0", bus.mmio_err); end
   endtask

   task automatic test_bad_requests;
      int rd_n, wr_n, cs_n, rdy_n, rc; logic [NS-1:0] cs_seen;
      run_txn(21'h283, 1'b1, 1'b0, 32'h0, 1, 4, '1, rd_n, wr_n, cs_n, rdy_n, rc, cs_seen);
      total++; if (rd_n + wr_n + cs_n !== 0) begin bad++; $display("FAIL bad_slot_strobes got rd=%0d wr=%0d cs=%0d want 0", rd_n, wr_n, cs_n); end
      total++; if (rc !== 2) begin bad++; $display("FAIL bad_slot_ready_cycle got=%0d want=2", rc); end
      total++; if (bus.mmio_err !== 1'b1 || bus.mmio_err_addr !== 21'h283) begin bad++; $display("FAIL bad_slot_err got=%b/%h want=1/283", bus.mmio_err, bus.mmio_err_addr); end
      total++; if (bus.mmio_rd_data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL bad_slot_rd_data got=%h want=deadbeef", bus.mmio_rd_data); end
      // Error stays set when err_clr coincides with a new error below.
      bus.err_clr = 1'b1;
      run_txn(21'h0C4, 1'b1, 1'b1, 32'h1111_2222, 1, 6, '0, rd_n, wr_n, cs_n, rdy_n, rc, cs_seen);
      bus.err_clr = 1'b0;
      total++; if (rd_n + wr_n + cs_n !== 0) begin bad++; $display("FAIL rdwr_strobes got rd=%0d wr=%0d cs=%0d want 0", rd_n, wr_n, cs_n); end
      total++; if (rc !== 2) begin bad++; $display("FAIL rdwr_ready_cycle got=%0d want=2", rc); end
      total++; if (bus.mmio_err !== 1'b0) begin bad++; $display("FAIL rdwr_err_clr_after got=%b want=0", bus.mmio_err); end
      total++; if (bus.mmio_err_addr !== 21'h0C4) begin bad++; $display("FAIL rdwr_err_addr got=%h want=0c4", bus.mmio_err_addr); end
      run_txn(21'h0C4, 1'b1, 1'b1, 32'h0, 0, 0, '0, rd_n, wr_n, cs_n, rdy_n, rc, cs_seen);
      total++; if (bus.mmio_err !== 1'b1) begin bad++; $display("FAIL rdwr_err got=%b want=1", bus.mmio_err); end
   endtask

   task automatic test_reset_mid;
      int rd_n, wr_n, cs_n, rdy_n, rc; logic [NS-1:0] cs_seen;
      bus.mmio_cs = 1'b1; bus.mmio_rd = 1'b1; bus.mmio_addr = 21'h080;
      @(posedge clk); #1;
      bus.mmio_cs = 1'b0; bus.mmio_rd = 1'b0;
      total++; if (mem_rd !== 1'b1 || slot_cs !== 16'h0010) begin bad++; $display("FAIL mid_access got rd=%b cs=%h want 1/0010", mem_rd, slot_cs); end
      #2 reset_n = 1'b0; #1;
      total++; if ({slot_cs, mem_rd, mem_wr, bus.mmio_ready} !== '0) begin bad++; $display("FAIL mid_reset_strobes got=%h/%b/%b/%b want 0", slot_cs, mem_rd, mem_wr, bus.mmio_ready); end
      total++; if ({bus.mmio_err, bus.mmio_err_addr, bus.mmio_rd_data} !== '0) begin bad++; $display("FAIL mid_reset_regs got=%b/%h/%h want 0", bus.mmio_err, bus.mmio_err_addr, bus.mmio_rd_data); end
      @(posedge clk); #1;
      total++; if (bus.mmio_ready !== 1'b0) begin bad++; $display("FAIL mid_reset_ready got=%b want=0", bus.mmio_ready); end
      reset_n = 1'b1;
      @(posedge clk); #1;
      run_txn(21'h020, 1'b1, 1'b0, 32'h0, 1, 1, '0, rd_n, wr_n, cs_n, rdy_n, rc, cs_seen);
      total++; if (rc !== 2 || bus.mmio_rd_data !== 32'hC0DE_0001) begin bad++; $display("FAIL post_reset_read got ready=%0d data=%h want 2/c0de0001", rc, bus.mmio_rd_data); end
   endtask

   initial begin
      bus.mmio_cs = 1'b0; bus.mmio_rd = 1'b0; bus.mmio_wr = 1'b0;
      bus.mmio_addr = '0; bus.mmio_wr_data = '0; bus.err_clr = 1'b0;
      slot_ack = '0;
      for (int i = 0; i < NS; i++) slot_data[i*DW +: DW] = 32'hC0DE_0000 | 32'(i);
      slot_data[3*DW +: DW] = 32'h1234_5678;
      slot_data[7*DW +: DW] = 32'h7777_0007;
      repeat (3) @(posedge clk);
      #1;
      test_reset;
      reset_n = 1'b1;
      @(posedge clk); #1;
      test_reset;
      test_read_fast;
      test_write_slow;
      test_timeout;
      test_ack_at_timeout;
      test_foreign_ack;
      test_bad_requests;
      test_reset_mid;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
